// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter: widths, FSM state encoding
// and the host request record carried through the request FIFO.
package vram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 12;
  localparam int VRAM_WORDS = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } host_req_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Host request/readback bus of the VRAM arbiter.
// master = host writer, slave = arbiter.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rdata, host_rvalid
  );

  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rdata, host_rvalid
  );

endinterface

// File: rtl/vram_req_fifo.sv
// Synchronous request FIFO with full/empty flags and occupancy count.
// No fall-through: a pushed entry becomes visible at the head one cycle later.
module vram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = store[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and a reset-free array maps to RAM.
  always_ff @(posedge clock) begin
    if (push_ok) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM owner: scanout wins vga_clock&&video_on slots, host FIFO and
// the clear engine share the rest. Optional host readback: VRAM_READBACK_EN.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_clock,
  input  logic              video_on,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  vram_arbiter_if.slave     host,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_val;
  logic              disp_pend;
  logic              disp_slot;
  logic              host_slot;
  logic              push;
  logic              pop;
  logic              push_we;
  host_req_t         push_req;
  host_req_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;

  assign disp_slot = vga_clock && video_on;
  assign host_slot = !disp_slot;
  assign clr_busy  = (state != ST_RUN);

  // Ready and RAM drive are forced low while reset is held so every output reads 0.
  assign host.host_ready = reset && !fifo_full && (state == ST_RUN);
  assign push = host.host_valid && host.host_ready;
  assign pop  = reset && host_slot && !fifo_empty && (state != ST_CLEAR);
  assign push_req = '{push_we, host.host_addr, host.host_wdata};

  vram_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(host_req_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy after this edge decides whether a clear must drain first.
  always_comb begin
    count_next = fifo_count;
    if (push) count_next = count_next + 1'b1;
    if (pop)  count_next = count_next - 1'b1;
  end

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      if (disp_slot) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (pop) begin
        mem_en    = 1'b1;
        mem_we    = head.we;
        mem_addr  = head.addr;
        mem_wdata = head.wdata;
      end else if (state == ST_CLEAR) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = clr_val;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_RUN;
      clr_addr   <= '0;
      clr_val    <= '0;
      disp_pend  <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      disp_pend  <= disp_slot;
      disp_valid <= disp_pend;
      if (disp_pend) disp_data <= mem_rdata;
      case (state)
        ST_RUN: begin
          if (clr_start) begin
            clr_val <= clr_data;
            state   <= (count_next != '0) ? ST_DRAIN : ST_CLEAR;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (host_slot) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef VRAM_READBACK_EN
  logic              host_pend;
  logic              host_rvalid_q;
  logic [DATA_W-1:0] host_rdata_q;

  assign push_we          = host.host_we;
  assign host.host_rdata  = host_rdata_q;
  assign host.host_rvalid = host_rvalid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      host_pend     <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      host_pend     <= pop && !head.we;
      host_rvalid_q <= host_pend;
      if (host_pend) host_rdata_q <= mem_rdata;
    end
  end
`else
  logic unused_host_we;

  assign unused_host_we   = host.host_we;
  assign push_we          = 1'b1;
  assign host.host_rdata  = '0;
  assign host.host_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural 1-cycle RAM, write log and
// a display-read scoreboard queue.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          vga_clock;
  logic          video_on;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          clr_start;
  logic [DW-1:0] clr_data;
  logic          clr_busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    ram [VRAM_WORDS];
  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    disp_exp[$];
  int               disp_pulses = 0;
  int               a5_bad = 0;
  bit               chk_a5 = 0;

  always #5 clock = ~clock;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .vga_clock  (vga_clock),
    .video_on   (video_on),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .host       (bus.slave),
    .clr_start  (clr_start),
    .clr_data   (clr_data),
    .clr_busy   (clr_busy),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Behavioural single-port RAM plus a log of every write it receives.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_q.push_back({mem_addr, mem_wdata});
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  always @(negedge clock) begin
    if (disp_valid) begin
      disp_pulses++;
      if (chk_a5 && disp_data !== 8'hA5) a5_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 0;
    bus.host_valid = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (bus.host_ready) done = 1;
      cycle();
    end
    bus.host_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL push_timeout addr=%h: host_ready never seen", a);
    end
  endtask

  task automatic wait_writes(input int n, input int bound, input string name);
    int i = 0;
    while (wr_q.size() < n && i < bound) begin
      cycle();
      i++;
    end
    if (wr_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s: got %0d writes, required %0d", name, wr_q.size(), n);
    end
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (clr_busy && i < 6000) begin
      cycle();
      i++;
    end
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: clr_busy=%b after %0d cycles, required 0", name, clr_busy, i);
    end
  endtask

  // One display slot at address a; the expected word goes on the scoreboard queue.
  task automatic disp_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    int got = 0;
    logic [DW-1:0] want;
    disp_addr = a;
    video_on  = 1'b1;
    vga_clock = 1'b1;
    disp_exp.push_back(exp);
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, a}) begin
      errors++;
      $display("FAIL %s_mem: en/we/addr=%b/%b/%h, required 1/0/%h", name, mem_en, mem_we, mem_addr, a);
    end
    cycle();
    vga_clock = 1'b0;
    video_on  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (disp_valid) begin
        got = k;
        break;
      end
    end
    want = disp_exp.pop_front();
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL %s_latency: disp_valid after %0d cycles, required 2", name, got);
    end
    checks++;
    if (disp_data !== want) begin
      errors++;
      $display("FAIL %s_data: disp_data=%h, required %h", name, disp_data, want);
    end
    cycle();
    checks++;
    if (disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: disp_valid=%b one cycle later, required 0", name, disp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    video_on = 1'b1;
    vga_clock = 1'b1;
    bus.host_valid = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({mem_en, mem_we, bus.host_ready, clr_busy, disp_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: en/we/ready/busy/dvalid=%b%b%b%b%b, required 00000",
               mem_en, mem_we, bus.host_ready, clr_busy, disp_valid);
    end
    checks++;
    if ({disp_data, bus.host_rdata, bus.host_rvalid} !== '0) begin
      errors++;
      $display("FAIL reset_data: disp_data=%h host_rdata=%h host_rvalid=%b, required 0",
               disp_data, bus.host_rdata, bus.host_rvalid);
    end
    bus.host_valid = 1'b0;
    video_on = 1'b0;
    vga_clock = 1'b0;
    reset = 1'b1;
    cycle();
    checks++;
    if (bus.host_ready !== 1'b1 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1/0", bus.host_ready, clr_busy);
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL reset_writes: %0d RAM writes during reset, required 0", wr_q.size());
    end
  endtask

  task automatic test_display();
    wr_q.delete();
    push_req(1'b1, 12'h040, 8'hA5);
    wait_writes(1, 20, "display_write");
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {12'h040, 8'hA5}) begin
      errors++;
      $display("FAIL display_write_value: log size=%0d first=%h, required 1 entry 040a5",
               wr_q.size(), wr_q.size() > 0 ? wr_q[0] : '0);
    end
    disp_read(12'h040, 8'hA5, "display_read");
  endtask

  task automatic test_back_pressure();
    logic [AW+DW-1:0] exp_wr[$];
    int accepts = 0, pops_bad = 0, slots = 0, base, mism = 0;
    bit acc;
    wr_q.delete();
    base = disp_pulses;
    a5_bad = 0;
    chk_a5 = 1;
    disp_addr = 12'h040;
    video_on = 1'b1;
    vga_clock = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_we = 1'b1;
    bus.host_addr = 12'h100;
    bus.host_wdata = 8'h10;
    for (int i = 0; i < 8; i++) begin
      acc = 0;
      @(negedge clock);
      slots++;
      if (mem_we) pops_bad++;
      if (bus.host_ready) begin
        exp_wr.push_back({bus.host_addr, bus.host_wdata});
        accepts++;
        acc = 1;
      end
      cycle();
      if (acc) begin
        bus.host_addr  = bus.host_addr + 1'b1;
        bus.host_wdata = bus.host_wdata + 1'b1;
      end
    end
    bus.host_valid = 1'b0;
    checks++;
    if (accepts != 4 || bus.host_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: accepts=%0d ready=%b, required 4/0", accepts, bus.host_ready);
    end
    for (int i = 0; i < 16; i++) begin
      vga_clock = (i % 2 == 0);
      @(negedge clock);
      if (vga_clock) begin
        slots++;
        if (mem_we) pops_bad++;
      end
      cycle();
    end
    video_on = 1'b0;
    vga_clock = 1'b0;
    repeat (3) cycle();
    chk_a5 = 0;
    checks++;
    if (pops_bad != 0) begin
      errors++;
      $display("FAIL bp_slot_steal: %0d writes in display slots, required 0", pops_bad);
    end
    checks++;
    if (disp_pulses - base != slots || a5_bad != 0) begin
      errors++;
      $display("FAIL bp_display: pulses=%0d bad=%0d, required %0d pulses 0 bad",
               disp_pulses - base, a5_bad, slots);
    end
    wait_writes(4, 20, "bp_drain");
    foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) mism++;
    checks++;
    if (mism != 0 || wr_q.size() != 4) begin
      errors++;
      $display("FAIL bp_order: %0d mismatched of %0d writes, required 0 of 4", mism, wr_q.size());
    end
  endtask

  task automatic test_clear();
    int bad = 0, n;
    logic [AW-1:0] ai;
    wr_q.delete();
    video_on = 1'b1;
    vga_clock = 1'b1;
    push_req(1'b1, 12'h200, 8'h01);
    push_req(1'b1, 12'h201, 8'h02);
    clr_data = 8'h3C;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    clr_data = 8'hFF;
    checks++;
    if (clr_busy !== 1'b1 || bus.host_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy: busy=%b ready=%b, required 1/0", clr_busy, bus.host_ready);
    end
    video_on = 1'b0;
    vga_clock = 1'b0;
    wait_idle("clear_done");
    n = wr_q.size();
    checks++;
    if (n != 2 + VRAM_WORDS) begin
      errors++;
      $display("FAIL clear_count: %0d writes when busy dropped, required %0d", n, 2 + VRAM_WORDS);
    end
    if (n > 0 && wr_q[0] !== {12'h200, 8'h01}) bad++;
    if (n > 1 && wr_q[1] !== {12'h201, 8'h02}) bad++;
    for (int i = 0; i < VRAM_WORDS && i + 2 < n; i++) begin
      ai = AW'(i);
      if (wr_q[i + 2] !== {ai, 8'h3C}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_sequence: %0d wrong writes, required 0", bad);
    end
    repeat (3) cycle();
    checks++;
    if (wr_q.size() != n) begin
      errors++;
      $display("FAIL clear_stop: %0d writes, required %0d", wr_q.size(), n);
    end
    for (int i = 0; i < 4; i++) disp_read(AW'($urandom_range(VRAM_WORDS - 1, 0)), 8'h3C, "clear_readback");
  endtask

  task automatic test_clear_ignored();
    int bad = 0;
    logic [AW-1:0] ai;
    wr_q.delete();
    clr_data = 8'h5A;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    repeat (10) cycle();
    clr_data = 8'hEE;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    wait_idle("ignored_done");
    repeat (20) cycle();
    checks++;
    if (wr_q.size() != VRAM_WORDS || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_count: %0d writes busy=%b, required %0d/0", wr_q.size(), clr_busy, VRAM_WORDS);
    end
    for (int i = 0; i < VRAM_WORDS && i < wr_q.size(); i++) begin
      ai = AW'(i);
      if (wr_q[i] !== {ai, 8'h5A}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ignored_data: %0d wrong writes, required 0", bad);
    end
    disp_read(AW'($urandom_range(VRAM_WORDS - 1, 0)), 8'h5A, "ignored_readback");
  endtask

  task automatic test_reset_mid_clear();
    wr_q.delete();
    clr_data = 8'h77;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    wait_writes(12'h200, 1000, "midclr_progress");
    reset = 1'b0;
    cycle();
    checks++;
    if ({clr_busy, bus.host_ready, mem_en, disp_valid} !== 4'b0 || disp_data !== '0) begin
      errors++;
      $display("FAIL midclr_reset: busy/ready/en/dvalid=%b%b%b%b disp_data=%h, required 0000/00",
               clr_busy, bus.host_ready, mem_en, disp_valid, disp_data);
    end
    checks++;
    if (wr_q.size() != 12'h200) begin
      errors++;
      $display("FAIL midclr_writes: %0d writes, required %0d", wr_q.size(), 12'h200);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (bus.host_ready !== 1'b1 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL midclr_release: ready=%b busy=%b, required 1/0", bus.host_ready, clr_busy);
    end
    repeat (5) cycle();
    checks++;
    if (wr_q.size() != 12'h200) begin
      errors++;
      $display("FAIL midclr_aborted: %0d writes, required %0d", wr_q.size(), 12'h200);
    end
    disp_read(12'h000, 8'h77, "midclr_low");
    disp_read(12'h1FF, 8'h77, "midclr_edge");
    disp_read(12'h200, 8'h5A, "midclr_untouched");
    disp_read(12'hFFF, 8'h5A, "midclr_top");
  endtask

`ifdef VRAM_READBACK_EN
  task automatic test_readback();
    logic [DW-1:0] rd_exp[$];
    logic [DW-1:0] want;
    int pulses = 0, wr_at_pulse = -1;
    logic [DW-1:0] seen = '0;
    wr_q.delete();
    push_req(1'b1, 12'h7FF, 8'h11);
    push_req(1'b0, 12'h7FF, 8'h00);
    rd_exp.push_back(8'h11);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bus.host_rvalid) begin
        pulses++;
        seen = bus.host_rdata;
        if (wr_at_pulse < 0) wr_at_pulse = wr_q.size();
      end
      cycle();
    end
    want = rd_exp.pop_front();
    checks++;
    if (pulses != 1 || seen !== want) begin
      errors++;
      $display("FAIL readback: pulses=%0d data=%h, required 1/%h", pulses, seen, want);
    end
    checks++;
    if (wr_at_pulse != 1) begin
      errors++;
      $display("FAIL readback_order: %0d writes before read data, required 1", wr_at_pulse);
    end
  endtask
`else
  task automatic test_readback();
    int pulses = 0;
    wr_q.delete();
    push_req(1'b0, 12'h7FE, 8'h22);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== '0) pulses++;
      cycle();
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {12'h7FE, 8'h22}) begin
      errors++;
      $display("FAIL no_readback_write: log size=%0d first=%h, required 1 entry 7fe22",
               wr_q.size(), wr_q.size() > 0 ? wr_q[0] : '0);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL no_readback_tied: %0d cycles with nonzero readback, required 0", pulses);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    vga_clock = 1'b0;
    video_on = 1'b0;
    disp_addr = '0;
    clr_start = 1'b0;
    clr_data = '0;
    bus.host_valid = 1'b0;
    bus.host_we = 1'b1;
    bus.host_addr = '0;
    bus.host_wdata = '0;
    test_reset();
    test_display();
    test_back_pressure();
    test_clear();
    test_clear_ignored();
    test_reset_mid_clear();
    test_readback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
